// File: rtl/wb_ipi_mailbox.sv
// wb_ipi_mailbox: Wishbone B3 classic responder with one receive FIFO per core.
// A push to window n's DATA register queues a word for core n. A read of DATA pops that word.
// irq_o[n] is high while mailbox n holds data and its IRQ_EN bit is set.
// Optional build macro WB_IPI_MAILBOX_ERR_EN: an access to a window at or above
// NUM_CORES answers with wb_err_o. Without it, such an access is acked and has no effect.
module wb_ipi_mailbox #(
  parameter int NUM_CORES  = 1,
  parameter int DEPTH_LOG2 = 3,
  parameter int ADR_W      = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic [ADR_W-1:0]     wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [NUM_CORES-1:0] irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WIN_W = ADR_W - 4;
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Handshake: a request is cyc & stb while no response is showing. The
  // registered response (ack or err) is high for exactly one cycle on the
  // edge after the request, and every side effect commits on that same edge.
  // A beat therefore takes two cycles at least, and a burst is served one beat at a time.
  logic             req;
  logic [WIN_W-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic [1:0]       reg_sel;
  logic             in_range;
  logic             resp_err;

  assign win      = wb_adr_i[ADR_W-1:4];
  assign win_idx  = win[IDX_W-1:0];
  assign reg_sel  = wb_adr_i[3:2];
  assign in_range = (32'(win) < 32'(NUM_CORES));
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

`ifdef WB_IPI_MAILBOX_ERR_EN
  assign resp_err = ~in_range;
`else
  assign resp_err = 1'b0;
`endif

  assign wb_rty_o = 1'b0;

  // Pins that have no effect on behaviour
  logic unused_pins;
  assign unused_pins = ^{wb_cti_i, wb_bte_i, wb_sel_i[3:1], wb_adr_i[1:0]};

  // Per-mailbox state
  logic [31:0]           mem     [NUM_CORES][DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr  [NUM_CORES];
  logic [DEPTH_LOG2-1:0] wr_ptr  [NUM_CORES];
  logic [DEPTH_LOG2:0]   count   [NUM_CORES];
  logic [NUM_CORES-1:0]  ovf;
  logic [NUM_CORES-1:0]  irq_en;
  logic [NUM_CORES-1:0]  empty;
  logic [NUM_CORES-1:0]  full;
  logic                  err_q;

  // Flags for each mailbox, taken from its occupancy count
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == CNT_FULL);
    end
  end

  // Decoded side effects of the current request, for an in-range window only
  logic do_push, do_pop, do_clear, do_ien;
  assign do_push  = req & in_range & wb_we_i  & (reg_sel == 2'd0);
  assign do_pop   = req & in_range & ~wb_we_i & (reg_sel == 2'd0) & ~empty[win_idx];
  assign do_clear = req & in_range & wb_we_i  & (reg_sel == 2'd3);
  assign do_ien   = req & in_range & wb_we_i  & (reg_sel == 2'd2) & wb_sel_i[0];

  // Read data mux for the addressed register
  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    if (in_range) begin
      case (reg_sel)
        2'd0: if (!empty[win_idx]) rd_data = mem[win_idx][rd_ptr[win_idx]];
        2'd1: begin
          rd_data[DEPTH_LOG2:0] = count[win_idx];
          rd_data[16]           = empty[win_idx];
          rd_data[17]           = full[win_idx];
          rd_data[18]           = ovf[win_idx];
        end
        2'd2: rd_data[0] = irq_en[win_idx];
        default: rd_data = '0;
      endcase
    end
  end

  // Mailbox storage. It has no reset because the count decides which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (do_push && !full[win_idx])
      mem[win_idx][wr_ptr[win_idx]] <= wb_dat_i;
  end

  // Pointers, counts, sticky overflow and interrupt enables
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ovf    <= '0;
      irq_en <= '0;
    end else begin
      if (do_push) begin
        if (full[win_idx]) begin
          ovf[win_idx] <= 1'b1;
        end else begin
          wr_ptr[win_idx] <= wr_ptr[win_idx] + PTR_ONE;
          count[win_idx]  <= count[win_idx] + CNT_ONE;
        end
      end
      if (do_pop) begin
        rd_ptr[win_idx] <= rd_ptr[win_idx] + PTR_ONE;
        count[win_idx]  <= count[win_idx] - CNT_ONE;
      end
      if (do_clear) begin
        rd_ptr[win_idx] <= '0;
        wr_ptr[win_idx] <= '0;
        count[win_idx]  <= '0;
        ovf[win_idx]    <= 1'b0;
      end
      if (do_ien)
        irq_en[win_idx] <= wb_dat_i[0];
    end
  end

  // Bus response: a single-cycle ack or err, with read data captured on the same edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      err_q    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req & ~resp_err;
      err_q    <= req & resp_err;
      if (req)
        wb_dat_o <= (resp_err || wb_we_i) ? 32'd0 : rd_data;
    end
  end

  assign wb_err_o = err_q;

  // Registered interrupts follow the committed mailbox state one cycle later
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_o <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++)
        irq_o[i] <= irq_en[i] & ~empty[i];
    end
  end

endmodule
